// File: rtl/pixel_pkg.sv
// Shared register map, field positions and frame FSM encoding for wb_pixel_buffer.
package pixel_pkg;

  localparam int unsigned NUM_PIX = 64;
  localparam int unsigned PIX_AW  = 6;
  localparam int unsigned PIX_W   = 24;

  localparam logic [7:0] REG_CTRL   = 8'd64;
  localparam logic [7:0] REG_STATUS = 8'd65;
  localparam logic [7:0] REG_BRIGHT = 8'd66;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_AUTO  = 1;
  localparam int unsigned CTRL_IE    = 2;

  localparam int unsigned STAT_BUSY     = 0;
  localparam int unsigned STAT_FDONE    = 1;
  localparam int unsigned STAT_FCNT_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2
  } frame_state_e;

  // (c * (b + 1)) >> 8 never exceeds 255, so 16 bits of product are enough.
  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'd0, c} * ({8'd0, b} + 16'd1);
    return 8'(prod >> 8);
  endfunction

endpackage

// File: rtl/pixel_ram.sv
// Pixel store: one synchronous byte-enabled write port, asynchronous CPU and LED read ports.
module pixel_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [2:0]    be_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [23:0]   wdata_i,
  output logic [23:0]   cpu_data_o,
  input  logic [AW-1:0] led_addr_i,
  output logic [23:0]   led_data_o
);

  logic [23:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned b = 0; b < 3; b++) begin
        if (be_i[b]) mem_q[cpu_addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign cpu_data_o = mem_q[cpu_addr_i];
  assign led_data_o = mem_q[led_addr_i];

endmodule

// File: rtl/wb_pixel_buffer.sv
// Wishbone-mapped LED pixel buffer with frame sequencing FSM and frame-done interrupt.
// Optional per-channel brightness scaling is enabled by defining PIXEL_BRIGHTNESS_EN.
module wb_pixel_buffer
  import pixel_pkg::*;
#(
  parameter int unsigned NUM_PIX = pixel_pkg::NUM_PIX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_stb_i,
  input  logic              wb_cyc_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  input  logic [PIX_AW-1:0] pix_addr,
  output logic [23:0]       pix_data,
  output logic              led_init,
  input  logic              led_done,
  output logic              irq
);

  localparam logic [7:0] PIX_LIMIT = 8'(NUM_PIX);

  logic         ack_q;
  logic [31:0]  dat_q;
  logic         auto_q, ie_q;
  logic         fdone_q;
  logic [7:0]   fcnt_q;
  logic         done_prev_q;
  logic         led_init_q;
  frame_state_e state_q;

  logic [7:0]   idx;
  logic         access, wr;
  logic         is_pix, is_ctrl, is_stat;
  logic         start_wr, fdone_clr, done_rise;
  logic [23:0]  ram_rdata, led_rdata;
  logic [31:0]  rdata;
  logic         unused_bits;

  assign idx     = wb_adr_i[9:2];
  assign access  = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr      = access & wb_we_i;
  assign is_pix  = idx < PIX_LIMIT;
  assign is_ctrl = idx == REG_CTRL;
  assign is_stat = idx == REG_STATUS;

  assign start_wr  = wr & is_ctrl & wb_sel_i[0] & wb_dat_i[CTRL_START];
  assign fdone_clr = wr & is_stat & wb_sel_i[0] & wb_dat_i[STAT_FDONE];
  assign done_rise = led_done & ~done_prev_q;

  assign unused_bits = ^{wb_adr_i[31:10], wb_adr_i[1:0], wb_dat_i[31:24], wb_sel_i[3]};

  pixel_ram #(
    .DEPTH (NUM_PIX),
    .AW    (PIX_AW)
  ) u_ram (
    .clk_i      (clk),
    .we_i       (wr & is_pix),
    .be_i       (wb_sel_i[2:0]),
    .cpu_addr_i (idx[PIX_AW-1:0]),
    .wdata_i    (wb_dat_i[23:0]),
    .cpu_data_o (ram_rdata),
    .led_addr_i (pix_addr),
    .led_data_o (led_rdata)
  );

`ifdef PIXEL_BRIGHTNESS_EN
  logic [7:0] bright_q;
  logic       is_bright;

  assign is_bright = idx == REG_BRIGHT;

  always_ff @(posedge clk) begin
    if (rst) begin
      bright_q <= 8'hFF;
    end else if (wr & is_bright & wb_sel_i[0]) begin
      bright_q <= wb_dat_i[7:0];
    end
  end

  always_comb begin
    pix_data = '0;
    for (int unsigned c = 0; c < 3; c++) begin
      pix_data[8*c +: 8] = scale_chan(led_rdata[8*c +: 8], bright_q);
    end
  end
`else
  assign pix_data = led_rdata;
`endif

  always_comb begin
    rdata = '0;
    if (is_pix) begin
      rdata[23:0] = ram_rdata;
    end else if (is_ctrl) begin
      rdata[CTRL_AUTO] = auto_q;
      rdata[CTRL_IE]   = ie_q;
    end else if (is_stat) begin
      rdata[STAT_BUSY]              = state_q != ST_IDLE;
      rdata[STAT_FDONE]             = fdone_q;
      rdata[STAT_FCNT_LSB +: 8]     = fcnt_q;
    end
`ifdef PIXEL_BRIGHTNESS_EN
    else if (is_bright) begin
      rdata[7:0] = bright_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= access;
      dat_q <= (access & ~wb_we_i) ? rdata : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      auto_q <= 1'b0;
      ie_q   <= 1'b0;
    end else if (wr & is_ctrl & wb_sel_i[0]) begin
      auto_q <= wb_dat_i[CTRL_AUTO];
      ie_q   <= wb_dat_i[CTRL_IE];
    end
  end

  // FDONE clear precedes the frame-done set below so a coincident edge wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      led_init_q  <= 1'b0;
      fdone_q     <= 1'b0;
      fcnt_q      <= '0;
      done_prev_q <= 1'b0;
    end else begin
      done_prev_q <= led_done;
      led_init_q  <= 1'b0;
      if (fdone_clr) fdone_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_wr) begin
            state_q    <= ST_START;
            led_init_q <= 1'b1;
          end
        end
        ST_START: begin
          state_q <= ST_BUSY;
        end
        ST_BUSY: begin
          if (done_rise) begin
            fdone_q <= 1'b1;
            fcnt_q  <= fcnt_q + 8'd1;
            if (auto_q) begin
              state_q    <= ST_START;
              led_init_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign led_init = led_init_q;
  assign irq      = fdone_q & ie_q;

endmodule

// File: tb/tb_wb_pixel_buffer.sv
// Self-checking bench for wb_pixel_buffer: cycle-level behavioural model plus directed literals.
module tb_wb_pixel_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0, wb_stb_i = 1'b0, wb_cyc_i = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic [5:0]  pix_addr = '0;
  logic [23:0] pix_data;
  logic        led_init;
  logic        led_done = 1'b0;
  logic        irq;

  always #5 clk = ~clk;

  wb_pixel_buffer #(.NUM_PIX(64)) dut (
    .clk(clk), .rst(rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .pix_addr(pix_addr), .pix_data(pix_data),
    .led_init(led_init), .led_done(led_done), .irq(irq)
  );

  int tests = 0;
  int fails = 0;
  int init_cnt = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  logic [23:0] m_pix [64];
  bit          m_pv  [64];
  bit          m_ack = 0, m_dat_v = 1, m_auto = 0, m_ie = 0, m_fdone = 0;
  bit          m_busy = 0, m_init = 0, m_prev = 0;
  logic [31:0] m_dat = '0;
  logic [7:0]  m_fcnt = '0;
  logic [7:0]  m_bright = 8'hFF;

  always @(posedge clk) begin : model
    bit acc, wr, rise, o_busy, o_init, o_auto, start;
    int idx;
    if (rst) begin
      m_ack = 0; m_dat = '0; m_dat_v = 1; m_auto = 0; m_ie = 0; m_fdone = 0;
      m_fcnt = '0; m_busy = 0; m_init = 0; m_prev = 0; m_bright = 8'hFF;
    end else begin
      idx    = int'(wb_adr_i[9:2]);
      acc    = wb_cyc_i && wb_stb_i && !m_ack;
      wr     = acc && wb_we_i;
      rise   = led_done && !m_prev;
      o_busy = m_busy; o_init = m_init; o_auto = m_auto; start = 0;
      m_dat = '0; m_dat_v = 1;
      if (acc && !wb_we_i) begin
        if (idx < 64) begin
          m_dat = {8'h00, m_pix[idx]};
          m_dat_v = m_pv[idx];
        end else if (idx == 64) m_dat = {29'd0, m_ie, m_auto, 1'b0};
        else if (idx == 65) m_dat = {16'd0, m_fcnt, 6'd0, m_fdone, m_busy};
`ifdef PIXEL_BRIGHTNESS_EN
        else if (idx == 66) m_dat = {24'd0, m_bright};
`endif
      end
      if (wr) begin
        if (idx < 64) begin
          for (int b = 0; b < 3; b++)
            if (wb_sel_i[b]) m_pix[idx][8*b +: 8] = wb_dat_i[8*b +: 8];
          if (wb_sel_i[2:0] == 3'b111) m_pv[idx] = 1;
        end else if (idx == 64 && wb_sel_i[0]) begin
          m_auto = wb_dat_i[1]; m_ie = wb_dat_i[2]; start = wb_dat_i[0];
        end else if (idx == 65 && wb_sel_i[0] && wb_dat_i[1]) m_fdone = 0;
`ifdef PIXEL_BRIGHTNESS_EN
        else if (idx == 66 && wb_sel_i[0]) m_bright = wb_dat_i[7:0];
`endif
      end
      m_init = 0;
      if (o_busy && !o_init && rise) begin
        m_fdone = 1;
        m_fcnt++;
        if (o_auto) m_init = 1;
        else m_busy = 0;
      end
      if (start && !o_busy) begin
        m_busy = 1;
        m_init = 1;
      end
      m_ack = acc;
      m_prev = led_done;
    end
  end

  function automatic logic [23:0] exp_pix(input int a);
    logic [23:0] r;
    r = m_pix[a];
`ifdef PIXEL_BRIGHTNESS_EN
    for (int c = 0; c < 3; c++) begin
      int ch;
      ch = int'(m_pix[a][8*c +: 8]);
      r[8*c +: 8] = 8'((ch * (int'(m_bright) + 1)) / 256);
    end
`endif
    return r;
  endfunction

  always @(negedge clk) begin
    if (led_init === 1'b1) init_cnt++;
    if (chk_en) begin
      chk("ack", {31'd0, wb_ack_o}, {31'd0, m_ack});
      if (m_ack && m_dat_v) chk("rdata", wb_dat_o, m_dat);
      chk("led_init", {31'd0, led_init}, {31'd0, m_init});
      chk("irq", {31'd0, irq}, {31'd0, m_fdone & m_ie});
      if (m_pv[pix_addr]) chk("pix_data", {8'd0, pix_data}, {8'd0, exp_pix(int'(pix_addr))});
    end
  end

  task automatic wb_xfer(input bit we, input int idx, input logic [31:0] d,
                         input logic [3:0] sel, output logic [31:0] r);
    int waited;
    waited = 0;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we;
    wb_adr_i = {22'($urandom), idx[7:0], 2'($urandom)};
    wb_dat_i = d; wb_sel_i = sel;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (wb_ack_o !== 1'b1 && waited < 8);
    chk("ack_latency", waited, 1);
    r = wb_dat_o;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_done();
    led_done = 1; @(posedge clk); #1;
    led_done = 0; @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    int c0;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_init", {31'd0, led_init}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rst = 0;
    chk_en = 1;
`ifdef PIXEL_BRIGHTNESS_EN
    wb_xfer(0, 66, 0, 4'hF, r); chk("rst_bright", r, 32'h0000_00FF);
`endif
    wb_xfer(0, 65, 0, 4'hF, r); chk("rst_status", r, 32'h0);

    for (int i = 0; i < 64; i++) wb_xfer(1, i, $urandom, 4'hF, r);

    wb_xfer(1, 5, 32'h0012_3456, 4'hF, r);
    wb_xfer(0, 5, 0, 4'hF, r); chk("px5_read", r, 32'h0012_3456);
    pix_addr = 6'd5; #1; chk("px5_led", {8'd0, pix_data}, 32'h0012_3456);

    wb_xfer(1, 0, 32'h0011_2233, 4'hF, r);
    wb_xfer(1, 0, 32'h0000_AB00, 4'h2, r);
    wb_xfer(0, 0, 0, 4'hF, r); chk("px0_bytesel", r, 32'h0011_AB33);

    wb_xfer(1, 1, 32'h00FF_8040, 4'hF, r);
    wb_xfer(1, 66, 32'h0000_007F, 4'hF, r);
    pix_addr = 6'd1; #1;
`ifdef PIXEL_BRIGHTNESS_EN
    chk("bright_7f", {8'd0, pix_data}, 32'h007F_4020);
    wb_xfer(1, 66, 32'h0000_00FF, 4'hF, r);
    chk("bright_ff", {8'd0, pix_data}, 32'h00FF_8040);
`else
    chk("raw_pix", {8'd0, pix_data}, 32'h00FF_8040);
    wb_xfer(0, 66, 0, 4'hF, r); chk("bright_off", r, 32'h0);
`endif

    c0 = init_cnt;
    wb_xfer(1, 64, 32'h1, 4'hF, r);
    chk("init_once", init_cnt, c0 + 1);
    wb_xfer(0, 65, 0, 4'hF, r); chk("busy_set", r, 32'h0000_0001);
    wb_xfer(1, 64, 32'h1, 4'hF, r);
    pulse_done();
    wb_xfer(0, 65, 0, 4'hF, r); chk("frame1_done", r, 32'h0000_0102);
    chk("no_restart", init_cnt, c0 + 1);

    c0 = init_cnt;
    wb_xfer(1, 64, 32'h6, 4'hF, r);
    wb_xfer(1, 64, 32'h7, 4'hF, r);
    chk("auto_start", init_cnt, c0 + 1);
    pulse_done();
    chk("auto_reinit", init_cnt, c0 + 2);
    chk("irq_set", {31'd0, irq}, 32'd1);
    wb_xfer(1, 65, 32'h2, 4'hF, r);
    chk("irq_clr", {31'd0, irq}, 32'd0);
    wb_xfer(1, 64, 32'h4, 4'hF, r);
    pulse_done();
    repeat (3) @(posedge clk);
    #1;
    chk("auto_stop", init_cnt, c0 + 2);
    wb_xfer(0, 65, 0, 4'hF, r); chk("auto_status", r, 32'h0000_0302);

    wb_xfer(1, 64, 32'h5, 4'hF, r);
    chk("irq_pre_rst", {31'd0, irq}, 32'd1);
    wb_xfer(0, 65, 0, 4'hF, r); chk("busy_pre_rst", r, 32'h0000_0303);
    rst = 1;
    @(posedge clk); #1;
    chk("rst_mid_init", {31'd0, led_init}, 32'd0);
    chk("rst_mid_irq", {31'd0, irq}, 32'd0);
    rst = 0;
    wb_xfer(0, 65, 0, 4'hF, r); chk("rst_mid_status", r, 32'h0);
    wb_xfer(0, 64, 0, 4'hF, r); chk("rst_mid_ctrl", r, 32'h0);

    for (int n = 0; n < 500; n++) begin
      int op;
      op = int'($urandom_range(0, 11));
      pix_addr = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 2) == 0) led_done = ~led_done;
      case (op)
        0, 1, 2, 3: wb_xfer(1, int'($urandom_range(0, 63)), $urandom, 4'($urandom), r);
        4, 5:       wb_xfer(0, int'($urandom_range(0, 63)), 0, 4'hF, r);
        6:          wb_xfer(1, 64, {29'd0, 3'($urandom)}, 4'($urandom), r);
        7:          wb_xfer(1, 65, {30'd0, 2'($urandom)}, 4'($urandom), r);
        8:          wb_xfer(0, int'($urandom_range(64, 255)), 0, 4'hF, r);
        9:          wb_xfer(1, int'($urandom_range(66, 255)), $urandom, 4'hF, r);
        default: begin
          @(posedge clk); #1;
        end
      endcase
    end

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_pixel_buffer.md
WB_PIXEL_BUFFER -- requirements
Module: wb_pixel_buffer

Interface
REQ-001 Parameter NUM_PIX, 64, number of 24-bit pixels held; fixes the pixel address width at 6 bits.
REQ-002 Ports: clk in 1 system clock; rst in 1 reset, synchronous, active-high.
REQ-003 Wishbone slave ports: wb_adr_i in 32, byte address; wb_dat_i in 32; wb_sel_i in 4; wb_we_i in 1; wb_stb_i in 1; wb_cyc_i in 1; wb_dat_o out 32; wb_ack_o out 1.
REQ-004 LED-stage ports: pix_addr in 6, pixel index from the LED driver; pix_data out 24, pixel word for pix_addr; led_init out 1, frame start; led_done in 1, held high by the driver after a frame completes.
REQ-005 Interrupt port: irq out 1, level interrupt to the CPU.

Function
REQ-006 The word index is wb_adr_i[9:2]: 0-63 PIXEL[n] (bits 23:0, RW); 64 CTRL; 65 STATUS; 66 BRIGHT. Other indices read 0 and ignore writes.
REQ-007 A cycle with wb_cyc_i & wb_stb_i & !wb_ack_o performs its access and asserts wb_ack_o on the next cycle for exactly 1 cycle. wb_ack_o deasserts the following cycle, so there is no back-to-back ack.
REQ-008 Writes apply on the access cycle under byte enables. wb_sel_i[3] is ignored for PIXEL. Read data is registered and valid with wb_ack_o.
REQ-009 pix_data is a combinational read of PIXEL[pix_addr], with 0-cycle latency. The LED stage samples data the cycle after it changes the address.
REQ-010 A CPU write and an LED read to the same pixel in the same cycle: pix_data shows the new value from the next cycle. Tearing within a frame is permitted.
REQ-011 CTRL fields: bit0 START (write-1 trigger, reads 0); bit1 AUTO (continuous refresh); bit2 IE (interrupt enable).
REQ-012 STATUS fields: bit0 BUSY (RO); bit1 FDONE (sticky, write-1-to-clear); bits15:8 FCNT (RO frame count, wraps 255 to 0).
REQ-013 Frame FSM states IDLE, START, BUSY.
REQ-014 IDLE goes to START when START is written with 1.
REQ-015 START drives led_init=1 for exactly 1 cycle, then moves to BUSY.
REQ-016 BUSY waits for a rising edge of led_done, detected by a registered previous value. On that edge: FDONE=1, FCNT+1, and the FSM goes to START if AUTO=1, otherwise to IDLE.
REQ-017 BUSY=1 in the START and BUSY states.
REQ-018 A START write while BUSY=1 is ignored.
REQ-019 Clearing AUTO mid-frame lets the current frame finish, then the FSM returns to IDLE.
REQ-020 A rising edge on led_done in the same cycle as a W1C write to FDONE leaves FDONE=1 (set wins).
REQ-021 irq = FDONE & IE.

Reset
REQ-022 While rst=1: wb_ack_o=0, wb_dat_o=0, led_init=0, irq=0, FSM=IDLE, CTRL=0, FDONE=0, FCNT=0, BRIGHT=0xFF, led_done history=0.
REQ-023 Pixel storage is not reset.
REQ-024 Reset mid-frame aborts the frame. The LED stage shares rst and is reset with this block.
REQ-025 A Wishbone cycle in flight during reset is not acked.

Configuration
REQ-026 Macro PIXEL_BRIGHTNESS_EN defined: BRIGHT[7:0] is RW. Each 8-bit channel of pix_data = (c*(BRIGHT+1))>>8, computed combinationally, so BRIGHT=0xFF is the identity.
REQ-027 Macro PIXEL_BRIGHTNESS_EN undefined: BRIGHT reads 0, writes are ignored, and pix_data is the raw pixel word. No multipliers are synthesized.

Structure
REQ-028 A shared package pixel_pkg holds NUM_PIX, the register word indices (64/65/66), the CTRL/STATUS bit positions and the FSM state encoding.
REQ-029 Sub-module pixel_ram: NUM_PIX x 24, one synchronous write port with 3 byte enables, and two asynchronous read ports (CPU and LED).

Verification
REQ-030 Write 0x00123456 to PIXEL[5] with sel=0xF, then read it back: ack comes 1 cycle after stb, and the read returns 0x00123456. pix_addr=5 gives pix_data=0x123456.
REQ-031 Write CTRL=0x1: led_init is high for exactly 1 cycle and STATUS.BUSY=1. Pulse led_done high: FDONE=1, FCNT=1, BUSY=0. A START written during BUSY produces no second led_init.
REQ-032 CTRL=0x6 (AUTO+IE) followed by CTRL=0x7: a new led_init follows each led_done rising edge and irq=1. Writing STATUS=0x2 drops irq. Writing CTRL=0x4 ends refresh after the current frame.
REQ-033 Byte-enable write sel=0x2, data 0x0000AB00 to PIXEL[0]=0x112233: PIXEL[0] becomes 0x11AB33.
REQ-034 With PIXEL_BRIGHTNESS_EN: BRIGHT=0x7F and PIXEL=0xFF8040 give pix_data=0x7F4020. BRIGHT=0xFF gives 0xFF8040 unchanged.
REQ-035 Assert rst in BUSY: the next cycle shows led_init=0, BUSY=0, CTRL=0, and irq=0.
